// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-memory signals of the load/store unit.
// The slave modport is the unit's view; the master modport is the core plus memory.
interface load_store_unit_if #(
    parameter int unsigned Width = 32
);
    logic             REQ;
    logic             WR;
    logic [2:0]       FUNCT3;
    logic [Width-1:0] ADDR;
    logic [Width-1:0] WDATA;
    logic             READY;
    logic             DONE;
    logic             ERR;
    logic [Width-1:0] RDATA;
    logic [Width-1:0] MA;
    logic [Width-1:0] MWD;
    logic             MWE;
    logic [Width-1:0] MRD;

    modport slave (
        input  REQ, WR, FUNCT3, ADDR, WDATA, MRD,
        output READY, DONE, ERR, RDATA, MA, MWD, MWE
    );

    modport master (
        output REQ, WR, FUNCT3, ADDR, WDATA, MRD,
        input  READY, DONE, ERR, RDATA, MA, MWD, MWE
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: word/byte/half loads with extension, SW direct, SB/SH by read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/HU/SH and W/SW accesses with ERR.
module load_store_unit #(
    parameter int unsigned Width = 32
) (
    input  logic             CLK,
    input  logic             RST,
    load_store_unit_if.slave bus
);
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif
    localparam logic [1:0] SzH = 2'b01;
    localparam logic [1:0] SzW = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, READ, WRITE} state_t;

    state_t           state_q, state_d;
    logic [Width-1:0] addr_q, wdata_q;
    logic [Width-1:0] merged_q, merged_d;
    logic [Width-1:0] rdata_q, rdata_d;
    logic [Width-1:0] load_val;
    logic [2:0]       funct3_q;
    logic             wr_q, valid_q;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             latch_req, req_valid, req_sub_store, mwe;

    // Width code legality, plus alignment when trapping is enabled.
    function automatic logic access_ok(input logic wr, input logic [2:0] f3, input logic [1:0] a_lo);
        logic ok;
        logic aligned;
        if (wr) begin
            ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end else begin
            ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        end
        case (f3[1:0])
            SzH:     aligned = ~a_lo[0];
            SzW:     aligned = (a_lo == 2'b00);
            default: aligned = 1'b1;
        endcase
        return ok && (aligned || !TrapEn);
    endfunction

    assign req_valid     = access_ok(bus.WR, bus.FUNCT3, bus.ADDR[1:0]);
    assign req_sub_store = bus.WR && req_valid && (bus.FUNCT3[1:0] != SzW);

    // Sign/zero extension of the memory read word.
    always_comb begin
        load_val = bus.MRD;
        case (funct3_q)
            3'b000:  load_val = {{(Width-8){bus.MRD[7]}}, bus.MRD[7:0]};
            3'b100:  load_val = {{(Width-8){1'b0}}, bus.MRD[7:0]};
            3'b001:  load_val = {{(Width-16){bus.MRD[15]}}, bus.MRD[15:0]};
            3'b101:  load_val = {{(Width-16){1'b0}}, bus.MRD[15:0]};
            default: load_val = bus.MRD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        merged_d  = merged_q;
        latch_req = 1'b0;
        mwe       = 1'b0;
        bus.READY = 1'b0;
        bus.MA    = addr_q;
        bus.MWD   = '0;
        case (state_q)
            IDLE: begin
                bus.READY = 1'b1;
                if (bus.REQ) begin
                    latch_req = 1'b1;
                    state_d   = req_sub_store ? READ : ACCESS;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                done_d  = 1'b1;
                err_d   = !valid_q;
                rdata_d = (valid_q && !wr_q) ? load_val : '0;
                if (valid_q && wr_q) begin
                    bus.MWD = wdata_q;
                    mwe     = 1'b1;
                end
            end
            READ: begin
                state_d  = WRITE;
                merged_d = funct3_q[0] ? {bus.MRD[Width-1:16], wdata_q[15:0]}
                                       : {bus.MRD[Width-1:8], wdata_q[7:0]};
            end
            WRITE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                rdata_d = '0;
                bus.MWD = merged_q;
                mwe     = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset must suppress a write even in the cycle it is raised.
    assign bus.MWE = mwe & ~RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            funct3_q <= 3'b000;
            valid_q  <= 1'b0;
            merged_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (latch_req) begin
                addr_q   <= bus.ADDR;
                wdata_q  <= bus.WDATA;
                wr_q     <= bus.WR;
                funct3_q <= bus.FUNCT3;
                valid_q  <= req_valid;
            end
            merged_q <= merged_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.DONE  = done_q;
    assign bus.ERR   = err_q;
    assign bus.RDATA = rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, directed cases and random traffic.
module tb_load_store_unit;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    load_store_unit_if #(.Width(32)) bus ();
    load_store_unit #(.Width(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    typedef struct {
        logic [31:0] rd;
        logic        er;
        int          due;
        int          tag;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          mwe_cnt = 0;
    int          n_ops = 0;
    logic [31:0] last_mwd = '0;
    logic        pend_we = 1'b0;
    logic [31:0] pend_a = '0;
    logic [31:0] pend_d = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    assign bus.MRD = {mem[8'(bus.MA[7:0] + 8'd3)], mem[8'(bus.MA[7:0] + 8'd2)],
                      mem[8'(bus.MA[7:0] + 8'd1)], mem[bus.MA[7:0]]};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mem32(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = mem[8'(a + 32'(i))];
        return w;
    endfunction

    task automatic poke32(input logic [31:0] a, input logic [31:0] v);
        for (int i = 0; i < 4; i++) begin
            mem[8'(a + 32'(i))]     = v[8*i +: 8];
            ref_mem[8'(a + 32'(i))] = v[8*i +: 8];
        end
    endtask

    // Architectural effect of one access on the reference byte array.
    task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output exp_t e);
        int          n;
        logic        ok;
        logic [31:0] w;
        n  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        ok = wr ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        if (TrapEn && (a % 32'(n)) != 0) ok = 1'b0;
        e.rd  = '0;
        e.er  = !ok;
        e.due = cyc + ((ok && wr && n < 4) ? 3 : 2);
        e.tag = n_ops;
        if (!ok) return;
        if (wr) begin
            for (int i = 0; i < n; i++) ref_mem[8'(a + 32'(i))] = wd[8*i +: 8];
        end else begin
            w = '0;
            for (int i = 0; i < n; i++) w[8*i +: 8] = ref_mem[8'(a + 32'(i))];
            if (!f3[2] && n < 4 && w[8*n-1]) w = w - (32'd1 << (8*n));
            e.rd = w;
        end
    endtask

    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int acc);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge CLK);
        while (!bus.READY && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        if (!bus.READY) begin
            check("ready_timeout", 32'(bus.READY), 32'd1);
            acc = -1;
            return;
        end
        bus.WR = wr; bus.FUNCT3 = f3; bus.ADDR = a; bus.WDATA = wd; bus.REQ = 1'b1;
        model(wr, f3, a, wd, e);
        sb_q.push_back(e);
        acc = cyc;
        n_ops++;
        @(posedge CLK);
        #1 bus.REQ = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        @(negedge CLK);
    endtask

    initial begin
        int          acc1, acc2, mism;
        logic [31:0] w;
        exp_t        e;
        bus.REQ = 1'b0; bus.WR = 1'b0; bus.FUNCT3 = 3'b000; bus.ADDR = '0; bus.WDATA = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        poke32(32'h10, 32'h55667788);

        fork
            // Monitor: capture memory writes and score every completion.
            forever begin
                @(negedge CLK);
                pend_we = bus.MWE; pend_a = bus.MA; pend_d = bus.MWD;
                if (bus.MWE) begin
                    mwe_cnt++;
                    last_mwd = bus.MWD;
                end
                if (!bus.DONE && bus.ERR) check("err_without_done", 32'(bus.ERR), 32'd0);
                if (bus.DONE) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 32'(bus.DONE), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check($sformatf("op%0d rdata", e.tag), bus.RDATA, e.rd);
                        check($sformatf("op%0d err", e.tag), 32'(bus.ERR), 32'(e.er));
                        check($sformatf("op%0d latency", e.tag), 32'(cyc), 32'(e.due));
                    end
                end
            end
            // Byte-addressed data memory, written on the clock edge.
            forever begin
                @(posedge CLK);
                if (pend_we) begin
                    for (int i = 0; i < 4; i++) mem[8'(pend_a + 32'(i))] = pend_d[8*i +: 8];
                end
                pend_we = 1'b0;
            end
        join_none

        // Reset, with REQ held high to show it is ignored.
        repeat (3) @(posedge CLK);
        bus.REQ = 1'b1;
        @(negedge CLK);
        check("rst_ready", 32'(bus.READY), 32'd1);
        check("rst_mwe", 32'(bus.MWE), 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0; bus.REQ = 1'b0;
        @(negedge CLK);
        check("post_rst_ready", 32'(bus.READY), 32'd1);
        check("post_rst_done", 32'(bus.DONE), 32'd0);
        check("post_rst_rdata", bus.RDATA, 32'd0);
        check("post_rst_ma", bus.MA, 32'd0);
        check("post_rst_mwd", bus.MWD, 32'd0);

        // Loads of every width at 0x10.
        issue(1'b0, 3'b010, 32'h10, 32'h0, acc1);
        issue(1'b0, 3'b000, 32'h10, 32'h0, acc1);
        issue(1'b0, 3'b100, 32'h10, 32'h0, acc1);
        issue(1'b0, 3'b001, 32'h10, 32'h0, acc1);
        issue(1'b0, 3'b101, 32'h10, 32'h0, acc1);
        drain();

        // SB read-modify-write.
        poke32(32'h20, 32'hAABBCCDD);
        mwe_cnt = 0;
        issue(1'b1, 3'b000, 32'h20, 32'h12345611, acc1);
        drain();
        check("sb_mwe_pulses", 32'(mwe_cnt), 32'd1);
        check("sb_mwd", last_mwd, 32'hAABBCC11);
        issue(1'b0, 3'b010, 32'h20, 32'h0, acc1);
        drain();

        // Reset arriving in WRITE of an SH.
        w = mem32(32'h20);
        check("idle_ready", 32'(bus.READY), 32'd1);
        bus.WR = 1'b1; bus.FUNCT3 = 3'b001; bus.ADDR = 32'h20; bus.WDATA = 32'h0000BEEF; bus.REQ = 1'b1;
        @(posedge CLK);
        #1 bus.REQ = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK);
        check("rst_in_write_mwe", 32'(bus.MWE), 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("rst_abort_ready", 32'(bus.READY), 32'd1);
        check("rst_abort_done", 32'(bus.DONE), 32'd0);
        check("rst_abort_mem", mem32(32'h20), w);

        // Invalid load code and misaligned SW.
        issue(1'b0, 3'b011, 32'h10, 32'h0, acc1);
        drain();
        mwe_cnt = 0;
        issue(1'b1, 3'b010, 32'h21, 32'hCAFEF00D, acc1);
        drain();
        check("sw21_mwe_pulses", 32'(mwe_cnt), TrapEn ? 32'd0 : 32'd1);
        issue(1'b0, 3'b010, 32'h21, 32'h0, acc1);
        drain();

        // Back-to-back: second request taken in the DONE cycle of the first.
        issue(1'b1, 3'b010, 32'h30, 32'h13572468, acc1);
        issue(1'b0, 3'b010, 32'h30, 32'h0, acc2);
        check("b2b_accept_cycle", 32'(acc2), 32'(acc1 + 2));
        drain();

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
            issue(1'($urandom), 3'($urandom), a, 32'($urandom), acc1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge CLK);
        end
        drain();

        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        check("mem_image_mismatches", 32'(mism), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
